chess_clock_ctrl: RTL
=====================

Name: chess_clock_ctrl

Overview:
- Per-player game clock and turn scheduler for the chess game-state FSM.
- Owns whose clock runs and counts each side's remaining seconds down.
- Hands the turn over on each committed move and raises a timeout flag when a side reaches zero.
- Flags feed the game-state FSM as a loss for the flagged side; game_over from that FSM freezes both clocks.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick (minimum 2).
- TIME_W, 12, width in bits of each player's seconds counter.
- INC_SEC, 0, seconds added per move; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; loads both clocks and starts white's clock.
- init_time  in  TIME_W  seconds loaded into both clocks on an accepted start.
- pause  in  1  level; while 1, prescaler and both clocks hold.
- white_done  in  1  one-cycle pulse; white has committed a legal move.
- black_done  in  1  one-cycle pulse; black has committed a legal move.
- game_over  in  1  level from the game-state FSM (checkmate or stalemate reached).
- white_time  out  TIME_W  white's remaining seconds, registered.
- black_time  out  TIME_W  black's remaining seconds, registered.
- white_turn  out  1  1 in state WRUN.
- running  out  1  (WRUN or BRUN) and not pause.
- white_flag  out  1  1 in state WFLAG (white out of time).
- black_flag  out  1  1 in state BFLAG (black out of time).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, prescaler 0, both times 0, all 1-bit outputs 0.
- States: IDLE, WRUN, BRUN, WFLAG, BFLAG, DONE.
- Start is accepted only in IDLE, WFLAG, BFLAG and DONE, and only when init_time != 0:
  - loads init_time into both times and clears the prescaler;
  - goes to WRUN on the next edge.
  - start with init_time == 0 is ignored. start in WRUN or BRUN is ignored.
- Prescaler:
  - counts 0..TICK_DIV-1 only in WRUN/BRUN with pause=0; holds otherwise.
  - tick = prescaler at TICK_DIV-1 and counting; prescaler wraps to 0 on tick.
- On tick, the active side's time decrements by 1 on that edge.
  - If that side's time was 1, the state moves to WFLAG or BFLAG on the same edge and its time becomes 0.
- Turn switch:
  - white_done in WRUN goes to BRUN; black_done in BRUN goes to WRUN.
  - The prescaler clears to 0 on the switch edge.
  - The wrong side's done is ignored, as is any done outside WRUN/BRUN.
  - done is honoured even while pause=1.
- Priority within one cycle, highest first: game_over (WRUN/BRUN go to DONE), then flag from decrement, then turn switch. With tick and done together:
  - the decrement applies first;
  - if it flags, the switch is dropped;
  - otherwise both the decrement and the switch occur.
- WFLAG, BFLAG and DONE hold their state and freeze both times until start or reset.
- game_over in IDLE/WFLAG/BFLAG has no effect.
- Decrement never goes below 0. There is no wrap-around.
- Latency: a done pulse shows on white_turn one cycle later. Time changes show on the edge after tick.

Optional Feature:
- Macro: CHESS_CLOCK_INCREMENT_EN.
- Defined: on an accepted turn switch, the mover's time becomes time + INC_SEC, saturating at 2^TIME_W-1.
  - If a tick falls in the same cycle, the decrement is applied first, then the increment.
  - No increment when the decrement flags.
- Undefined: no increment logic; INC_SEC is ignored.

Decomposition:
- Package chess_clock_pkg holds:
  - the state enum (IDLE, WRUN, BRUN, WFLAG, BFLAG, DONE, 3 bits; unused encodings recover to IDLE);
  - a TIME_MAX constant helper.
- Sub-module chess_tick_gen: parameterised by TICK_DIV; inputs enable and clear; output tick.

Test Plan:
- TICK_DIV=4, TIME_W=12, start with init_time=3 -> WRUN on the next cycle, both times 3; white_time becomes 2 four counting cycles later; black_time stays 3.
- white_done 6 cycles after start -> BRUN, white_time frozen at 2; black_time becomes 2 four cycles after the switch (prescaler cleared).
- White idles from init 3 -> white_time 0 and white_flag=1 after 12 cycles; a later white_done, black_done or game_over has no effect; start with init_time=5 -> WRUN, both times 5.
- pause=1 for 10 cycles mid-second (prescaler at 2) -> times and prescaler unchanged, running=0; after release, decrement occurs 2 cycles later.
- Same cycle: game_over=1, white_done=1 and tick in WRUN -> DONE, white decrement applied, no switch, both times then frozen.
- CHESS_CLOCK_INCREMENT_EN, INC_SEC=2:
  - white at 2 gives white_done -> white_time 4;
  - white at 4095 gives done -> 4095;
  - tick coinciding with done at time 1 -> white_flag, no increment.

Source files
------------

// File: rtl/chess_clock_pkg.sv
//==============================================================================
// chess_clock_pkg - shared state encoding and limits for the chess clock (rev 1.0)
//==============================================================================
`default_nettype none

package chess_clock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRUN  = 3'd1,
    BRUN  = 3'd2,
    WFLAG = 3'd3,
    BFLAG = 3'd4,
    DONE  = 3'd5
  } clk_state_t;

  function automatic longint unsigned time_max(input int w);
    time_max = (64'd1 << w) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chess_tick_gen.sv
//==============================================================================
// chess_tick_gen - one-second prescaler, emits tick on its last count (rev 1.0)
//==============================================================================
`default_nettype none

module chess_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/chess_clock_ctrl.sv
//==============================================================================
// chess_clock_ctrl - per-player game clock and turn scheduler (rev 1.0)
// Optional: define CHESS_CLOCK_INCREMENT_EN to add INC_SEC per committed move.
//==============================================================================
`default_nettype none

module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int TIME_W   = 12,
  parameter int INC_SEC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TIME_W-1:0] init_time,
  input  logic              pause,
  input  logic              white_done,
  input  logic              black_done,
  input  logic              game_over,
  output logic [TIME_W-1:0] white_time,
  output logic [TIME_W-1:0] black_time,
  output logic              white_turn,
  output logic              running,
  output logic              white_flag,
  output logic              black_flag
);

  clk_state_t        state, state_n;
  logic [TIME_W-1:0] white_n, black_n;
  logic              in_run, start_ok, tick, white_hit, black_hit, switch_ok;

`ifdef CHESS_CLOCK_INCREMENT_EN
  localparam logic [TIME_W-1:0] TMAX = TIME_W'(time_max(TIME_W));

  function automatic logic [TIME_W-1:0] add_inc(input logic [TIME_W-1:0] t);
    logic [TIME_W:0] sum;
    sum = {1'b0, t} + (TIME_W+1)'(INC_SEC);
    add_inc = (sum > {1'b0, TMAX}) ? TMAX : sum[TIME_W-1:0];
  endfunction
`endif

  assign in_run    = (state == WRUN) || (state == BRUN);
  assign running   = in_run && !pause;
  assign start_ok  = start && (init_time != '0) && !in_run;
  // A side reaching zero on this tick outranks its own done pulse.
  assign white_hit = tick && (state == WRUN) && (white_time == TIME_W'(1));
  assign black_hit = tick && (state == BRUN) && (black_time == TIME_W'(1));
  assign switch_ok = !game_over &&
                     (((state == WRUN) && white_done && !white_hit) ||
                      ((state == BRUN) && black_done && !black_hit));

  chess_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (running),
    .clear  (start_ok || switch_ok),
    .tick   (tick)
  );

  always_comb begin
    state_n = state;
    white_n = white_time;
    black_n = black_time;
    case (state)
      IDLE, WFLAG, BFLAG, DONE: begin
        if (start_ok) begin
          state_n = WRUN;
          white_n = init_time;
          black_n = init_time;
        end
      end
      WRUN: begin
        if (tick && (white_time != '0)) white_n = white_time - 1'b1;
        if (game_over) begin
          state_n = DONE;
        end else if (white_hit) begin
          state_n = WFLAG;
        end else if (white_done) begin
          state_n = BRUN;
`ifdef CHESS_CLOCK_INCREMENT_EN
          white_n = add_inc(white_n);
`endif
        end
      end
      BRUN: begin
        if (tick && (black_time != '0)) black_n = black_time - 1'b1;
        if (game_over) begin
          state_n = DONE;
        end else if (black_hit) begin
          state_n = BFLAG;
        end else if (black_done) begin
          state_n = WRUN;
`ifdef CHESS_CLOCK_INCREMENT_EN
          black_n = add_inc(black_n);
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      white_time <= '0;
      black_time <= '0;
      white_turn <= 1'b0;
      white_flag <= 1'b0;
      black_flag <= 1'b0;
    end else begin
      state      <= state_n;
      white_time <= white_n;
      black_time <= black_n;
      white_turn <= (state_n == WRUN);
      white_flag <= (state_n == WFLAG);
      black_flag <= (state_n == BFLAG);
    end
  end

endmodule

`default_nettype wire
